// File: rtl/rr_arb8_sel.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb8_sel
// Purpose  : Eight-requester round-robin arbiter producing the 3-bit binary
//            select for a 3:8 decoder stage. A grant is held until the owner
//            releases, drops its request, or reaches the HOLD_MAX cycle limit.
//            Every grant is followed by at least one idle cycle, so the
//            decoded one-hot enable never moves directly between channels.
// Ports    : clk          - rising-edge clock
//            rst_n        - asynchronous active-low reset
//            req_i[7:0]   - request lines, bit k = channel k
//            release_i    - owner done (only looked at while granted)
//            y_o[2:0]     - granted channel index (decoder select)
//            gnt_valid_o  - y_o is a live grant (decoder output enable)
//            timeout_o    - one-cycle pulse: last grant was ended by HOLD_MAX
// Params   : HOLD_MAX     - max consecutive grant cycles, 1..255; 0 = no limit
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb8_sel #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       release_i,
  output logic [2:0] y_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Hold counter value at which the limit fires (grant has then been valid
  // HOLD_MAX cycles). Unused when the limit is disabled.
  localparam logic       HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [2:0] y_q, y_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick;
  logic       pick_found;
  logic [2:0] scan_idx;
  logic       exit_rel;
  logic       exit_drop;
  logic       exit_lim;

  // Circular priority scan starting one above the last owner; the first
  // set request encountered wins. 3-bit index arithmetic wraps 7->0.
  always_comb begin
    pick       = 3'd0;
    pick_found = 1'b0;
    scan_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = last_idx_q + 3'd1 + 3'(k);
      if (!pick_found && req_i[scan_idx]) begin
        pick_found = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  assign exit_rel  = release_i;
  assign exit_drop = ~req_i[y_q];
  assign exit_lim  = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          y_d        = pick;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        if (exit_rel || exit_drop || exit_lim) begin
          state_d    = IDLE;
          last_idx_d = y_q;
          // A limit hit that coincides with a normal exit is not a timeout.
          timeout_d  = exit_lim && !exit_rel && !exit_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      y_q        <= 3'd0;
      last_idx_q <= 3'd7;
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // The state flop itself is the grant-valid register.
  assign y_o         = y_q;
  assign gnt_valid_o = (state_q == GRANT);
  assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb8_sel
// Purpose  : Self-checking bench for rr_arb8_sel. Two instances (HOLD_MAX=15
//            and HOLD_MAX=4) share stimulus; each is compared every cycle
//            against a behavioural model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb8_sel;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;

  logic [2:0] y15, y4;
  logic       gv15, gv4;
  logic       to15, to4;

  int total;
  int bad;

  rr_arb8_sel #(.HOLD_MAX(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
    .y_o(y15), .gnt_valid_o(gv15), .timeout_o(to15)
  );

  rr_arb8_sel #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
    .y_o(y4), .gnt_valid_o(gv4), .timeout_o(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: m_cnt counts cycles the current grant has been valid.
  int m_hold [2];
  bit m_busy [2];
  int m_y    [2];
  int m_last [2];
  int m_cnt  [2];
  bit m_to   [2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_y[i] = 0; m_last[i] = 7; m_cnt[i] = 0; m_to[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int  c;
    bit  found;
    bit  lim;
    bit  norm;
    if (!m_busy[i]) begin
      m_to[i] = 0;
      found   = 0;
      for (int k = 1; k <= 8; k++) begin
        c = (m_last[i] + k) % 8;
        if (!found && req[c]) begin
          found   = 1;
          m_y[i]  = c;
        end
      end
      if (found) begin
        m_busy[i] = 1;
        m_cnt[i]  = 1;
      end
    end else begin
      lim  = (m_hold[i] != 0) && (m_cnt[i] >= m_hold[i]);
      norm = rel || !req[m_y[i]];
      if (lim || norm) begin
        m_busy[i] = 0;
        m_last[i] = m_y[i];
        m_to[i]   = lim && !norm;
      end else begin
        m_cnt[i]++;
        m_to[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("y15",  int'(y15),  m_y[0]);
    chk("gv15", int'(gv15), int'(m_busy[0]));
    chk("to15", int'(to15), int'(m_to[0]));
    chk("y4",   int'(y4),   m_y[1]);
    chk("gv4",  int'(gv4),  int'(m_busy[1]));
    chk("to4",  int'(to4),  int'(m_to[1]));
  endtask

  // One clock: inputs already applied are sampled at the edge, model follows,
  // outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    total     = 0;
    bad       = 0;
    m_hold[0] = 15;
    m_hold[1] = 4;
    rst_n     = 1'b1;
    req       = 8'h00;
    rel       = 1'b0;
    #2;
    do_reset();
    chk("reset_y", int'(y15), 0);
    chk("reset_gv", int'(gv15), 0);
    chk("reset_to", int'(to15), 0);

    // 1: sole requester 0 times out after 15 cycles, re-granted after gap.
    req = 8'h01;
    step();
    chk("t1_first_y", int'(y15), 0);
    chk("t1_first_gv", int'(gv15), 1);
    n = 1;
    for (int c = 0; c < 20 && gv15; c++) begin
      step();
      if (gv15) n++;
    end
    chk("t1_hold_len", n, 15);
    chk("t1_timeout", int'(to15), 1);
    step();
    chk("t1_regrant_gv", int'(gv15), 1);
    chk("t1_regrant_y", int'(y15), 0);
    chk("t1_to_clear", int'(to15), 0);

    // 2: all requesting, release in 2nd grant cycle -> strict rotation.
    do_reset();
    req = 8'hFF;
    step();
    for (int g = 0; g < 9; g++) begin
      chk("t2_grant_y", int'(y15), g % 8);
      chk("t2_grant_gv", int'(gv15), 1);
      rel = 1'b0;
      step();
      chk("t2_second_gv", int'(gv15), 1);
      rel = 1'b1;
      step();
      chk("t2_gap_gv", int'(gv15), 0);
      rel = 1'b0;
      step();
    end

    // 3: after channel 5, requests {7,5,2} -> 7, 2, 5.
    do_reset();
    req = 8'h20;
    step();
    chk("t3_y5", int'(y15), 5);
    rel = 1'b1;
    req = 8'b1010_0100;
    step();
    rel = 1'b0;
    step();
    chk("t3_y7", int'(y15), 7);
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    chk("t3_y2", int'(y15), 2);
    rel = 1'b1;
    step();
    rel = 1'b0;
    step();
    chk("t3_y5b", int'(y15), 5);

    // 4: owner 3 drops request -> normal exit, next requester above 3 wins.
    do_reset();
    req = 8'h08;
    step();
    chk("t4_y3", int'(y15), 3);
    req = 8'h12;
    step();
    chk("t4_drop_gv", int'(gv15), 0);
    chk("t4_drop_to", int'(to15), 0);
    step();
    chk("t4_next_y", int'(y15), 4);
    chk("t4_next_gv", int'(gv15), 1);

    // 5: HOLD_MAX=4, release coincides with the limit -> no timeout.
    do_reset();
    req = 8'h08;
    step();
    n = 0;
    if (gv4) n++;
    step(); if (gv4) n++;
    step(); if (gv4) n++;
    step(); if (gv4) n++;
    rel = 1'b1;
    step();
    rel = 1'b0;
    chk("t5_len", n, 4);
    chk("t5_gv_low", int'(gv4), 0);
    chk("t5_no_timeout", int'(to4), 0);

    // 6: asynchronous reset in the middle of a grant to channel 6.
    do_reset();
    req = 8'h40;
    step();
    chk("t6_y6", int'(y15), 6);
    req = 8'hFF;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_gv", int'(gv15), 0);
    chk("t6_async_y", int'(y15), 0);
    chk("t6_async_gv4", int'(gv4), 0);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_after_y", int'(y15), 0);
    chk("t6_after_gv", int'(gv15), 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'($urandom_range(0, 255));
        1:       req = 8'(1 << $urandom_range(0, 7));
        2:       req = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
        default: req = req;
      endcase
      rel = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
